// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divided-clock checker.
package clk_div_pkg;

  // Number of flops in the clk_in synchronizer before edge detection.
  localparam int SYNC_STAGES = 2;

  // Checker FSM: waiting for first edge, measuring, or locked.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    LOCK = 2'd2
  } chk_state_t;

endpackage

// File: rtl/clk_div_checker_sync.sv
// Synchronizes the asynchronous divided clock into the clk domain and
// flags the cycle on which a synchronized rising edge is seen.
module sync_edge_det
  import clk_div_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Synchronizer shift chain plus one delay flop for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, as real hardware does.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/clk_div_checker.sv
// Measures high time, low time and period of a divided clock in clk
// cycles, checks each period against the expected ratio and duty cycle,
// and reports measurements, lock, error and stuck status.
module clk_div_checker
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = 5,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  localparam int unsigned GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  EXP_C     = CNT_W'(EXP_PERIOD);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_CNT);

  // Synchronized level and rising-edge strobe of clk_in.
  logic s2;
  logic rise;

  sync_edge_det u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .async_i(clk_in),
    .level_o(s2),
    .rise_o (rise)
  );

  logic [CNT_W-1:0]  hi_acc_q, hi_acc_d;
  logic [CNT_W-1:0]  lo_acc_q, lo_acc_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  chk_state_t        state_q, state_d;

  logic [CNT_W-1:0]  period_q, high_q, low_q;
  logic              meas_valid_q, locked_q, err_q, stuck_q;
  logic              stuck_d, err_d, capture;

  logic [CNT_W-1:0]  meas_sum;
  logic [CNT_W-1:0]  meas_diff;
  logic              meas_good;
  logic              timeout_hit;

  // Count high and low samples; a rise restarts the period with its own
  // cycle as the first high sample. Both counters saturate at TIMEOUT.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hi_acc_d = hi_acc_q;
    lo_acc_d = lo_acc_q;
    if (rise) begin
      hi_acc_d = CNT_W'(1);
      lo_acc_d = '0;
    end else if (s2) begin
      if (hi_acc_q != TIMEOUT_C) hi_acc_d = hi_acc_q + CNT_W'(1);
    end else begin
      if (lo_acc_q != TIMEOUT_C) lo_acc_d = lo_acc_q + CNT_W'(1);
    end
  end

  // Judge the period that a rise is about to close. Saturation keeps the
  // sum within CNT_W since TIMEOUT is below half the counter range.
  always_comb begin
    meas_sum    = hi_acc_q + lo_acc_q;
    meas_diff   = (hi_acc_q >= lo_acc_q) ? (hi_acc_q - lo_acc_q)
                                         : (lo_acc_q - hi_acc_q);
    meas_good   = (meas_sum == EXP_C) && (meas_diff <= CNT_W'(1));
    timeout_hit = (hi_acc_q == TIMEOUT_C) || (lo_acc_q == TIMEOUT_C);
  end

  // Next-state logic: a rise takes priority over a coincident timeout.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    stuck_d    = stuck_q;
    err_d      = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = MEAS;
          stuck_d    = 1'b0;
          good_cnt_d = '0;
        end
      end
      MEAS, LOCK: begin
        if (rise) begin
          capture = 1'b1;
          if (meas_good) begin
            good_cnt_d = (good_cnt_q == LOCK_C) ? good_cnt_q
                                                : good_cnt_q + GOOD_W'(1);
            state_d    = (good_cnt_d == LOCK_C) ? LOCK : MEAS;
          end else begin
            err_d      = 1'b1;
            good_cnt_d = '0;
            state_d    = MEAS;
          end
        end else if (timeout_hit) begin
          state_d    = IDLE;
          stuck_d    = 1'b1;
          err_d      = 1'b1;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        good_cnt_d = '0;
      end
    endcase
  end

  // State, accumulators and good-measurement counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      hi_acc_q   <= '0;
      lo_acc_q   <= '0;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_acc_q   <= hi_acc_d;
      lo_acc_q   <= lo_acc_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  // Registered outputs; measurement fields only change on a capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_q     <= '0;
      high_q       <= '0;
      low_q        <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      meas_valid_q <= capture;
      locked_q     <= (state_d == LOCK);
      err_q        <= err_d;
      stuck_q      <= stuck_d;
      if (capture) begin
        period_q <= meas_sum;
        high_q   <= hi_acc_q;
        low_q    <= lo_acc_q;
      end
    end
  end

  assign period     = period_q;
  assign high_cnt   = high_q;
  assign low_cnt    = low_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// Scoreboard bench for clk_div_checker: stimulus issues clk_in periods and
// pushes expected reports; a monitor pops them as the DUT reports.
module tb_clk_div_checker;

  localparam int CNT_W = 8;
  localparam int EXP   = 5;
  localparam int LOCKN = 4;
  localparam int TO    = 20;

  logic             clk = 1'b0;
  logic             rstn;
  logic             clk_in;
  logic [CNT_W-1:0] period, high_cnt, low_cnt;
  logic             meas_valid, locked, err, stuck;

  clk_div_checker #(
    .CNT_W(CNT_W), .EXP_PERIOD(EXP), .LOCK_CNT(LOCKN), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .clk_in(clk_in),
    .period(period), .high_cnt(high_cnt), .low_cnt(low_cnt),
    .meas_valid(meas_valid), .locked(locked), .err(err), .stuck(stuck)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_meas;
    int hi;
    int lo;
    bit err;
    bit locked;
    bit stuck;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: whether a period is open, its shape, good run.
  bit armed   = 1'b0;
  int prev_h  = 0;
  int prev_l  = 0;
  int good_run = 0;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // A rising edge of clk_in closes the open period (if any) and opens one.
  task automatic model_rise();
    exp_t e;
    int   p;
    bit   good;
    if (armed) begin
      p    = prev_h + prev_l;
      good = (p == EXP) && (prev_h - prev_l <= 1) && (prev_l - prev_h <= 1);
      if (good) begin
        good_run = (good_run < LOCKN) ? good_run + 1 : LOCKN;
      end else begin
        good_run = 0;
      end
      e.is_meas = 1'b1;
      e.hi      = prev_h;
      e.lo      = prev_l;
      e.err     = !good;
      e.locked  = (good_run == LOCKN);
      e.stuck   = 1'b0;
      sb_q.push_back(e);
    end
    armed = 1'b1;
  endtask

  task automatic drive_period(input int h, input int l);
    model_rise();
    prev_h = h;
    prev_l = l;
    @(negedge clk) clk_in = 1'b1;
    repeat (h - 1) @(negedge clk);
    @(negedge clk) clk_in = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  // Hold clk_in high long enough to exceed the timeout, then drop it.
  task automatic drive_stuck(input int h, input int l);
    exp_t e;
    model_rise();
    if (h >= TO) begin
      e.is_meas = 1'b0;
      e.hi      = 0;
      e.lo      = 0;
      e.err     = 1'b1;
      e.locked  = 1'b0;
      e.stuck   = 1'b1;
      sb_q.push_back(e);
      good_run = 0;
      armed    = 1'b0;
    end
    @(negedge clk) clk_in = 1'b1;
    repeat (h - 1) @(negedge clk);
    @(negedge clk) clk_in = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  // Monitor: every measurement or error pulse is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && (meas_valid || err)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_report: got mv=%0b err=%0b period=%0d hi=%0d lo=%0d, none expected",
                 meas_valid, err, period, high_cnt, low_cnt);
      end else begin
        e = sb_q.pop_front();
        if (e.is_meas) begin
          if (!meas_valid || err != e.err || locked != e.locked || stuck != e.stuck ||
              int'(period) != e.hi + e.lo || int'(high_cnt) != e.hi || int'(low_cnt) != e.lo) begin
            errors++;
            $display("FAIL meas: got mv=%0b p=%0d hi=%0d lo=%0d err=%0b lk=%0b st=%0b expected mv=1 p=%0d hi=%0d lo=%0d err=%0b lk=%0b st=%0b",
                     meas_valid, period, high_cnt, low_cnt, err, locked, stuck,
                     e.hi + e.lo, e.hi, e.lo, e.err, e.locked, e.stuck);
          end
        end else begin
          if (meas_valid || !err || locked || !stuck) begin
            errors++;
            $display("FAIL timeout: got mv=%0b err=%0b lk=%0b st=%0b expected mv=0 err=1 lk=0 st=1",
                     meas_valid, err, locked, stuck);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3*CNT_W+3:0] outs;
    int h, l;

    clk_in = 1'b0;
    rstn   = 1'b0;
    #3;
    outs = {period, high_cnt, low_cnt, meas_valid, locked, err, stuck};
    check("reset_outputs", int'(outs), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // odd divide by 5: first report 2/3, lock on the 4th.
    repeat (6) drive_period(2, 3);
    // Ratio change to 7 while locked: error, lock lost and never regained.
    repeat (3) drive_period(3, 4);
    // Relock, then a duty error at the right period.
    repeat (6) drive_period(3, 2);
    repeat (4) drive_period(1, 4);
    // Relock, then stall clk_in high past the timeout.
    repeat (6) drive_period(2, 3);
    drive_stuck(30, 5);
    check("stuck_set", int'(stuck), 1);
    check("stuck_unlocked", int'(locked), 0);
    drive_period(2, 3);
    check("stuck_cleared", int'(stuck), 0);
    repeat (5) drive_period(2, 3);

    // Randomized mix of good and off-ratio periods.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        h = $urandom_range(2, 3);
        l = EXP - h;
      end else begin
        h = $urandom_range(1, 6);
        l = $urandom_range(1, 6);
      end
      drive_period(h, l);
    end

    // Lock, let the last report drain, then reset mid-period.
    repeat (6) drive_period(2, 3);
    drive_period(2, 6);
    check("pre_reset_drained", sb_q.size(), 0);
    check("pre_reset_locked", int'(locked), 1);
    #2;
    rstn = 1'b0;
    #1;
    outs = {period, high_cnt, low_cnt, meas_valid, locked, err, stuck};
    check("async_reset_outputs", int'(outs), 0);
    armed    = 1'b0;
    good_run = 0;
    @(negedge clk);
    @(negedge clk) rstn = 1'b1;
    drive_period(2, 3);
    drive_period(2, 3);
    drive_period(3, 2);

    repeat (12) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
